vernier_ps_averager: RTL and testbench

- Parametrised successor to the tap-code→picosecond map: a pipelined Vernier TDC post-processor.
- Input: a stream of raw tap codes.
- Per code: range-check, scale by a programmable per-tap step, then accumulate 2^LOG2_N accepted samples into a rounded, saturated picosecond average.
- Sits between the Vernier delay-line encoder and the ETS sweep controller / AXI register bank.

---
 rtl/vernier_ps_averager_if.sv | 25 ++
 rtl/vernier_ps_averager.sv | 132 +++++++++++++
 tb/tb_vernier_ps_averager.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vernier_ps_averager_if.sv
// Tap-code stream in, averaged picosecond result out.
interface vernier_ps_averager_if #(
   parameter int unsigned CODE_W = 7,
   parameter int unsigned OUT_W  = 16
);
   logic              clear;
   logic              code_valid;
   logic [CODE_W-1:0] code;
   logic              code_ovf;
   logic              avg_valid;
   logic [OUT_W-1:0]  avg_ps;
   logic              avg_sat;
   logic [15:0]       rej_cnt;
   logic              busy;

   modport master (
      output clear, code_valid, code, code_ovf,
      input  avg_valid, avg_ps, avg_sat, rej_cnt, busy
   );

   modport slave (
      input  clear, code_valid, code, code_ovf,
      output avg_valid, avg_ps, avg_sat, rej_cnt, busy
   );
endinterface

// File: rtl/vernier_ps_averager.sv
// Vernier TDC post-processor: range-check each tap code, scale it to
// picoseconds, and average 2^LOG2_N accepted samples with round-half-up
// and saturation to OUT_W bits.
module vernier_ps_averager #(
   parameter int unsigned CODE_W   = 7,
   parameter int unsigned STEP_PS  = 11,
   parameter int unsigned CODE_MIN = 2,
   parameter int unsigned CODE_MAX = 120,
   parameter int unsigned LOG2_N   = 4,
   parameter int unsigned OUT_W    = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   vernier_ps_averager_if.slave bus
);

   localparam int unsigned PS_W   = CODE_W + 8;
   localparam int unsigned ACC_W  = PS_W + LOG2_N;
   localparam int unsigned RND_W  = ACC_W + 1;
   localparam int unsigned AVG_W  = PS_W + 1;
   localparam int unsigned CNT_W  = LOG2_N;

   localparam logic [CODE_W-1:0] CMIN     = CODE_W'(CODE_MIN);
   localparam logic [CODE_W-1:0] CMAX     = CODE_W'(CODE_MAX);
   localparam logic [PS_W-1:0]   STEP     = PS_W'(STEP_PS);
   localparam logic [RND_W-1:0]  RND_HALF = RND_W'(1) << (LOG2_N - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = '1;

   typedef enum logic {
      S_IDLE,
      S_ACC
   } state_t;

   state_t            state;
   logic              acc_en;
   logic [PS_W-1:0]   code_ps;
   logic              s1_valid;
   logic [PS_W-1:0]   s1_ps;
   logic [15:0]       rej_q;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic [ACC_W-1:0]  sum;
   logic [RND_W-1:0]  rnd;
   logic [AVG_W-1:0]  avg;
   logic              sat;
   logic              avg_valid_q;
   logic [OUT_W-1:0]  avg_ps_q;
   logic              avg_sat_q;

   assign acc_en  = !bus.code_ovf && (bus.code >= CMIN) && (bus.code <= CMAX);
   assign code_ps = PS_W'(bus.code) * STEP;

   // Stage 1: register accepted samples, count rejected ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_ps    <= '0;
         rej_q    <= '0;
      end else if (bus.clear) begin
         s1_valid <= 1'b0;
         rej_q    <= '0;
      end else begin
         s1_valid <= bus.code_valid && acc_en;
         if (bus.code_valid && acc_en)
            s1_ps <= code_ps;
         if (bus.code_valid && !acc_en && (rej_q != '1))
            rej_q <= rej_q + 16'd1;
      end
   end

   // Batch sum with the incoming stage-1 sample, rounded half up.
   always_comb begin
      sum = acc + ACC_W'(s1_ps);
      rnd = {1'b0, sum} + RND_HALF;
      avg = rnd[RND_W-1:LOG2_N];
   end

   if (OUT_W < AVG_W) begin : g_sat
      assign sat = |avg[AVG_W-1:OUT_W];
   end else begin : g_nosat
      assign sat = 1'b0;
   end

   // Stage 2: accumulation FSM with registered average outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         acc         <= '0;
         cnt         <= '0;
         avg_valid_q <= 1'b0;
         avg_ps_q    <= '0;
         avg_sat_q   <= 1'b0;
      end else if (bus.clear) begin
         state       <= S_IDLE;
         acc         <= '0;
         cnt         <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         avg_valid_q <= 1'b0;
         if (s1_valid) begin
            case (state)
               S_IDLE: begin
                  acc   <= ACC_W'(s1_ps);
                  cnt   <= CNT_W'(1);
                  state <= S_ACC;
               end
               S_ACC: begin
                  if (cnt == CNT_LAST) begin
                     avg_valid_q <= 1'b1;
                     avg_ps_q    <= sat ? '1 : OUT_W'(avg);
                     avg_sat_q   <= sat;
                     acc         <= '0;
                     cnt         <= '0;
                     state       <= S_IDLE;
                  end else begin
                     acc <= sum;
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.avg_valid = avg_valid_q;
   assign bus.avg_ps    = avg_ps_q;
   assign bus.avg_sat   = avg_sat_q;
   assign bus.rej_cnt   = rej_q;
   assign bus.busy      = (cnt != '0) || s1_valid;

endmodule

// File: tb/tb_vernier_ps_averager.sv
// Directed bench for vernier_ps_averager: a default 16-bit instance and an
// OUT_W=10 instance share the same stimulus.
module tb_vernier_ps_averager;

   logic clk;
   logic rst_n;
   int unsigned cyc;
   int unsigned last_cyc;
   int unsigned n_cmp;
   int unsigned n_bad;

   vernier_ps_averager_if #(.CODE_W(7), .OUT_W(16)) i16 ();
   vernier_ps_averager_if #(.CODE_W(7), .OUT_W(10)) i10 ();

   vernier_ps_averager #(.OUT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));
   vernier_ps_averager #(.OUT_W(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(i10));

   typedef struct {
      int unsigned cyc;
      int unsigned ps;
      bit          sat;
   } pulse_t;

   pulse_t q16[$];
   pulse_t q10[$];

   typedef struct {
      int unsigned code0;
      int unsigned inc;
      int unsigned ps16;
      bit          sat16;
      int unsigned ps10;
      bit          sat10;
   } batch_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every average pulse with the cycle it appeared in.
   always @(negedge clk) begin
      if (i16.avg_valid) q16.push_back('{cyc, 32'(i16.avg_ps), i16.avg_sat});
      if (i10.avg_valid) q10.push_back('{cyc, 32'(i10.avg_ps), i10.avg_sat});
   end

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int unsigned c, input bit ovf, input bit clr);
      @(negedge clk);
      i16.code_valid = v; i16.code = 7'(c); i16.code_ovf = ovf; i16.clear = clr;
      i10.code_valid = v; i10.code = 7'(c); i10.code_ovf = ovf; i10.clear = clr;
      last_cyc = cyc;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) drive(1'b0, 0, 1'b0, 1'b0);
   endtask

   function automatic pulse_t get16(input int unsigned idx);
      pulse_t p = '{0, 0, 1'b0};
      if (q16.size() > idx) p = q16[idx];
      return p;
   endfunction

   function automatic pulse_t get10(input int unsigned idx);
      pulse_t p = '{0, 0, 1'b0};
      if (q10.size() > idx) p = q10[idx];
      return p;
   endfunction

   // Expect exactly one pulse per instance at exp_cyc with the given values.
   task automatic check_one(input string tag, input int unsigned exp_cyc,
                            input int unsigned ps16, input bit sat16,
                            input int unsigned ps10, input bit sat10);
      pulse_t p;
      @(negedge clk); #1;
      check({tag, ".n16"}, q16.size(), 1);
      check({tag, ".n10"}, q10.size(), 1);
      p = get16(0);
      check({tag, ".cyc16"}, p.cyc, exp_cyc);
      check({tag, ".ps16"}, p.ps, ps16);
      check({tag, ".sat16"}, p.sat, sat16);
      p = get10(0);
      check({tag, ".cyc10"}, p.cyc, exp_cyc);
      check({tag, ".ps10"}, p.ps, ps10);
      check({tag, ".sat10"}, p.sat, sat10);
      check({tag, ".busy"}, i16.busy, 0);
      q16.delete();
      q10.delete();
   endtask

   batch_t tbl[5];
   int unsigned exp_c;
   int unsigned exp_c2;
   pulse_t pa;
   pulse_t pb;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      i16.code_valid = 1'b0; i16.code = '0; i16.code_ovf = 1'b0; i16.clear = 1'b0;
      i10.code_valid = 1'b0; i10.code = '0; i10.code_ovf = 1'b0; i10.clear = 1'b0;

      tbl[0] = '{10,  0, 110,  1'b0, 110,  1'b0};
      tbl[1] = '{2,   1, 105,  1'b0, 105,  1'b0};  // sum 1672, 104.5 rounds up
      tbl[2] = '{120, 0, 1320, 1'b0, 1023, 1'b1};  // CODE_MAX accepted, 10-bit clips
      tbl[3] = '{2,   0, 22,   1'b0, 22,   1'b0};  // CODE_MIN accepted
      tbl[4] = '{93,  0, 1023, 1'b0, 1023, 1'b0};  // exactly 2^10-1, no clip

      idle(2);
      @(negedge clk); #1;
      check("rst.avg_valid", i16.avg_valid, 0);
      check("rst.avg_ps", i16.avg_ps, 0);
      check("rst.avg_sat", i16.avg_sat, 0);
      check("rst.rej_cnt", i16.rej_cnt, 0);
      check("rst.busy", i16.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 5; i++) begin
         for (int unsigned s = 0; s < 16; s++)
            drive(1'b1, tbl[i].code0 + s * tbl[i].inc, 1'b0, 1'b0);
         exp_c = last_cyc + 2;
         idle(4);
         check_one($sformatf("tbl%0d", i), exp_c, tbl[i].ps16, tbl[i].sat16,
                   tbl[i].ps10, tbl[i].sat10);
         check($sformatf("tbl%0d.rej", i), i16.rej_cnt, 0);
      end

      // Rejects interleaved with 16 accepted code=22 samples.
      for (int unsigned s = 0; s < 5; s++) drive(1'b1, 22, 1'b0, 1'b0);
      drive(1'b1, 1, 1'b0, 1'b0);
      for (int unsigned s = 0; s < 5; s++) drive(1'b1, 22, 1'b0, 1'b0);
      drive(1'b1, 121, 1'b0, 1'b0);
      drive(1'b1, 50, 1'b1, 1'b0);
      for (int unsigned s = 0; s < 6; s++) drive(1'b1, 22, 1'b0, 1'b0);
      exp_c = last_cyc + 2;
      idle(4);
      check_one("rej", exp_c, 242, 1'b0, 242, 1'b0);
      check("rej.cnt16", i16.rej_cnt, 3);
      check("rej.cnt10", i10.rej_cnt, 3);

      // Partial batch discarded by clear; the clear-cycle sample is ignored.
      for (int unsigned s = 0; s < 5; s++) drive(1'b1, 30, 1'b0, 1'b0);
      drive(1'b1, 100, 1'b0, 1'b1);
      drive(1'b0, 0, 1'b0, 1'b0);
      #1;
      check("clr.busy", i16.busy, 0);
      check("clr.rej", i16.rej_cnt, 0);
      check("clr.hold_ps", i16.avg_ps, 242);
      for (int unsigned s = 0; s < 16; s++) drive(1'b1, 20, 1'b0, 1'b0);
      exp_c = last_cyc + 2;
      idle(4);
      check_one("clr", exp_c, 220, 1'b0, 220, 1'b0);

      // Clear in the cycle the average is due suppresses it.
      for (int unsigned s = 0; s < 16; s++) drive(1'b1, 10, 1'b0, 1'b0);
      drive(1'b0, 0, 1'b0, 1'b1);
      idle(4);
      @(negedge clk); #1;
      check("sup.n16", q16.size(), 0);
      check("sup.hold_ps", i16.avg_ps, 220);
      check("sup.busy", i16.busy, 0);
      q16.delete();
      q10.delete();

      // Back-to-back batches, no gap.
      for (int unsigned s = 0; s < 16; s++) drive(1'b1, 10, 1'b0, 1'b0);
      exp_c = last_cyc + 2;
      for (int unsigned s = 0; s < 16; s++) drive(1'b1, 100, 1'b0, 1'b0);
      exp_c2 = last_cyc + 2;
      idle(4);
      @(negedge clk); #1;
      check("b2b.n16", q16.size(), 2);
      pa = get16(0);
      pb = get16(1);
      check("b2b.cyc0", pa.cyc, exp_c);
      check("b2b.ps0", pa.ps, 110);
      check("b2b.cyc1", pb.cyc, exp_c2);
      check("b2b.gap", pb.cyc - pa.cyc, 16);
      check("b2b.ps1", pb.ps, 1100);
      pb = get10(1);
      check("b2b.ps1_10", pb.ps, 1023);
      check("b2b.sat1_10", pb.sat, 1);
      q16.delete();
      q10.delete();

      // Asynchronous reset mid-batch.
      drive(1'b1, 0, 1'b0, 1'b0);
      for (int unsigned s = 0; s < 8; s++) drive(1'b1, 10, 1'b0, 1'b0);
      drive(1'b0, 0, 1'b0, 1'b0);
      check("ar.pre_rej", i16.rej_cnt, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar.avg_ps16", i16.avg_ps, 0);
      check("ar.avg_sat10", i10.avg_sat, 0);
      check("ar.avg_valid", i16.avg_valid, 0);
      check("ar.rej_cnt", i16.rej_cnt, 0);
      check("ar.busy", i16.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      for (int unsigned s = 0; s < 16; s++) drive(1'b1, 10, 1'b0, 1'b0);
      exp_c = last_cyc + 2;
      idle(4);
      check_one("ar", exp_c, 110, 1'b0, 110, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
